fp_addsub_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor with valid/ready flow control, round-to-nearest-even and special-value handling. It supersedes the single-cycle, truncating 32-bit `addr` adder in the FPU datapath. It accepts one operation per cycle and returns results three cycles later in order. Operand widths follow the `EXP_W`/`MAN_W` parameters, so the same block serves single and reduced formats.

---
 rtl/fp_addsub_pipe_if.sv | 35 +++
 rtl/fp_addsub_pipe.sv | 230 +++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fp_addsub_pipe_if                                      |
// | Description : Operand/result handshake bundle for fp_addsub_pipe.    |
// |               The master side offers operands and accepts results;   |
// |               the slave side is the adder pipeline.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface fp_addsub_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [3:0]   out_flags;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface
`default_nettype wire

// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fp_addsub_pipe                                         |
// | Description : Three-stage IEEE-754-style add/subtract with           |
// |               valid/ready flow control, round-to-nearest-even,       |
// |               denormal flush and NaN/inf/over/underflow handling.    |
// |               S1 align, S2 add, S3 normalise/round (output regs).    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_addsub_pipe_if.slave bus
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int XW   = MAN_W + 4;          // hidden, fraction, guard, round, sticky
  localparam int SW   = XW + 1;             // plus carry
  localparam int EW   = EXP_W + 2;          // internal exponent, two's complement
  localparam int LZ_W = $clog2(XW + 1);
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [W-1:0]     QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  // Whole pipeline advances together; nothing moves while the output is stalled.
  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // ---------------------------------------------------------------- S1 --
  logic               a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [EXP_W-1:0]   a_exp, b_exp;
  logic [W-2:0]       a_mag, b_mag, big_mag, sml_mag;
  logic [MAN_W:0]     big_man, sml_man;
  logic               swap;
  logic [31:0]        shamt;
  logic [2*XW-1:0]    wide;

  logic               s1_valid_q;
  logic               s1_sign_a_d, s1_sign_a_q, s1_sign_b_d, s1_sign_b_q;
  logic [EXP_W-1:0]   s1_exp_d, s1_exp_q;
  logic [XW-1:0]      s1_ma_d, s1_ma_q, s1_mb_d, s1_mb_q;
  logic               s1_spec_d, s1_spec_q;
  logic [W-1:0]       s1_sdata_d, s1_sdata_q;
  logic [3:0]         s1_sflags_d, s1_sflags_q;

  // Decode, order by magnitude, align the smaller operand and resolve special inputs.
  always_comb begin
    a_sign = bus.in_a[W-1];
    b_sign = bus.in_b[W-1] ^ bus.in_op;
    a_exp  = bus.in_a[W-2:MAN_W];
    b_exp  = bus.in_b[W-2:MAN_W];
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_inf  = (a_exp == EXP_MAX) && (bus.in_a[MAN_W-1:0] == '0);
    b_inf  = (b_exp == EXP_MAX) && (bus.in_b[MAN_W-1:0] == '0);
    a_nan  = (a_exp == EXP_MAX) && (bus.in_a[MAN_W-1:0] != '0);
    b_nan  = (b_exp == EXP_MAX) && (bus.in_b[MAN_W-1:0] != '0);
    // Denormals are flushed: their fraction must not influence ordering.
    a_mag  = a_zero ? '0 : bus.in_a[W-2:0];
    b_mag  = b_zero ? '0 : bus.in_b[W-2:0];
    swap   = (b_mag > a_mag);
    big_mag = swap ? b_mag : a_mag;
    sml_mag = swap ? a_mag : b_mag;
    s1_sign_a_d = swap ? b_sign : a_sign;
    s1_sign_b_d = swap ? a_sign : b_sign;
    s1_exp_d    = big_mag[W-2:MAN_W];
    big_man = {(big_mag[W-2:MAN_W] != '0), big_mag[MAN_W-1:0]};
    sml_man = {(sml_mag[W-2:MAN_W] != '0), sml_mag[MAN_W-1:0]};
    s1_ma_d = {big_man, 3'b000};
    shamt   = 32'(big_mag[W-2:MAN_W] - sml_mag[W-2:MAN_W]);
    wide    = {sml_man, 3'b000, {XW{1'b0}}} >> shamt;
    if (shamt >= 32'(XW - 1)) begin
      s1_mb_d = {{(XW-1){1'b0}}, |sml_man};
    end else begin
      s1_mb_d = {wide[2*XW-1:XW+1], wide[XW] | (|wide[XW-1:0])};
    end

    s1_spec_d   = 1'b0;
    s1_sdata_d  = '0;
    s1_sflags_d = 4'b0000;
    if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
      s1_spec_d   = 1'b1;
      s1_sdata_d  = QNAN;
      s1_sflags_d = 4'b1000;
    end else if (a_inf) begin
      s1_spec_d  = 1'b1;
      s1_sdata_d = {a_sign, EXP_MAX, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      s1_spec_d  = 1'b1;
      s1_sdata_d = {b_sign, EXP_MAX, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      s1_spec_d  = 1'b1;
      s1_sdata_d = {a_sign & b_sign, {(W-1){1'b0}}};
    end
  end

  // S1 pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_a_q <= 1'b0;
      s1_sign_b_q <= 1'b0;
      s1_exp_q    <= '0;
      s1_ma_q     <= '0;
      s1_mb_q     <= '0;
      s1_spec_q   <= 1'b0;
      s1_sdata_q  <= '0;
      s1_sflags_q <= '0;
    end else if (adv) begin
      s1_valid_q  <= bus.in_valid;
      s1_sign_a_q <= s1_sign_a_d;
      s1_sign_b_q <= s1_sign_b_d;
      s1_exp_q    <= s1_exp_d;
      s1_ma_q     <= s1_ma_d;
      s1_mb_q     <= s1_mb_d;
      s1_spec_q   <= s1_spec_d;
      s1_sdata_q  <= s1_sdata_d;
      s1_sflags_q <= s1_sflags_d;
    end
  end

  // ---------------------------------------------------------------- S2 --
  logic [SW-1:0]      s2_sum_d, s2_sum_q;
  logic               s2_valid_q, s2_sign_q, s2_spec_q;
  logic [EXP_W-1:0]   s2_exp_q;
  logic [W-1:0]       s2_sdata_q;
  logic [3:0]         s2_sflags_q;

  // Magnitude add/subtract; A >= B so the difference is never negative.
  always_comb begin
    if (s1_sign_a_q ^ s1_sign_b_q) begin
      s2_sum_d = {1'b0, s1_ma_q} - {1'b0, s1_mb_q};
    end else begin
      s2_sum_d = {1'b0, s1_ma_q} + {1'b0, s1_mb_q};
    end
  end

  // S2 pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_exp_q    <= '0;
      s2_sum_q    <= '0;
      s2_spec_q   <= 1'b0;
      s2_sdata_q  <= '0;
      s2_sflags_q <= '0;
    end else if (adv) begin
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s1_sign_a_q;
      s2_exp_q    <= s1_exp_q;
      s2_sum_q    <= s2_sum_d;
      s2_spec_q   <= s1_spec_q;
      s2_sdata_q  <= s1_sdata_q;
      s2_sflags_q <= s1_sflags_q;
    end
  end

  // ---------------------------------------------------------------- S3 --
  logic [LZ_W-1:0]    lz;
  logic [XW-1:0]      norm;
  logic [EW-1:0]      e_norm, e_fin;
  logic [MAN_W+1:0]   mant_r;
  logic [MAN_W-1:0]   frac_fin;
  logic               rnd_up, inexact;
  logic [W-1:0]       res_data_d, out_data_q;
  logic [3:0]         res_flags_d, out_flags_q;
  logic               out_valid_q;

  // Normalise, round to nearest even, then apply the exception priority.
  always_comb begin
    lz = LZ_W'(XW);
    for (int i = 0; i < XW; i++) begin
      if (s2_sum_q[i]) lz = LZ_W'(XW - 1 - i);
    end
    if (s2_sum_q[SW-1]) begin
      norm   = {s2_sum_q[SW-1:2], s2_sum_q[1] | s2_sum_q[0]};
      e_norm = {2'b00, s2_exp_q} + EW'(1);
    end else begin
      norm   = s2_sum_q[XW-1:0] << lz;
      e_norm = {2'b00, s2_exp_q} - EW'(lz);
    end
    inexact = norm[2] | norm[1] | norm[0];
    rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r  = {1'b0, norm[XW-1:3]} + (MAN_W+2)'(rnd_up);
    if (mant_r[MAN_W+1]) begin
      e_fin    = e_norm + EW'(1);
      frac_fin = mant_r[MAN_W:1];
    end else begin
      e_fin    = e_norm;
      frac_fin = mant_r[MAN_W-1:0];
    end

    res_data_d  = {s2_sign_q, e_fin[EXP_W-1:0], frac_fin};
    res_flags_d = {3'b000, inexact};
    if (s2_spec_q) begin
      res_data_d  = s2_sdata_q;
      res_flags_d = s2_sflags_q;
    end else if (s2_sum_q == '0) begin
      res_data_d  = '0;
      res_flags_d = 4'b0000;
    end else if (!e_fin[EW-1] && (e_fin >= {2'b00, EXP_MAX})) begin
      res_data_d  = {s2_sign_q, EXP_MAX, {MAN_W{1'b0}}};
      res_flags_d = 4'b0101;
    end else if (e_norm[EW-1] || (e_norm == '0)) begin
      res_data_d  = {s2_sign_q, {(W-1){1'b0}}};
      res_flags_d = 4'b0011;
    end
  end

  // S3 / output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else if (adv) begin
      out_valid_q <= s2_valid_q;
      out_data_q  <= res_data_d;
      out_flags_q <= res_flags_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_flags = out_flags_q;
endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fp_addsub_pipe                                      |
// | Description : Directed self-checking bench for fp_addsub_pipe.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_fp_addsub_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  logic [35:0] exp_q[$];
  string       tag_q[$];
  int          out_cyc[$];

  always #5 clk = ~clk;

  fp_addsub_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Cycle counter for throughput checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: compare each transferred result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious result", 64'd1, 64'd0);
      end else begin
        check_eq(tag_q.pop_front(), {28'd0, bus.out_flags, bus.out_data}, {28'd0, exp_q.pop_front()});
        out_cyc.push_back(cyc);
      end
    end
  end

  // Offer one operation starting at posedge+1; returns just after the accept edge.
  task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic op, input logic [31:0] r, input logic [3:0] f);
    int tries = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    @(negedge clk);
    while (!bus.in_ready && tries < 50) begin
      @(posedge clk); #1;
      @(negedge clk);
      tries++;
    end
    if (!bus.in_ready) begin
      check_eq({tag, " accept timeout"}, 64'd0, 64'd1);
    end else begin
      exp_q.push_back({f, r});
      tag_q.push_back(tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic latency(input string tag);
    int n = 1;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(tag, 64'(n), 64'd3);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) check_eq("drain timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("reset out_data",  64'(bus.out_data),  64'd0);
    check_eq("reset out_flags", 64'(bus.out_flags), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("in_ready after reset", 64'(bus.in_ready), 64'd1);

    // Single op latency
    send("1+2", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    idle();
    latency("latency");
    drain();

    // Back-to-back throughput
    out_cyc.delete();
    for (int i = 0; i < 8; i++)
      send($sformatf("b2b%0d", i), 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    idle();
    drain();
    check_eq("b2b count", 64'(out_cyc.size()), 64'd8);
    if (out_cyc.size() == 8) check_eq("b2b span", 64'(out_cyc[7] - out_cyc[0]), 64'd7);

    // Directed vectors
    send("1-1",       32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    send("-0+-0",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    send("tie",       32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    send("above tie", 32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001);
    send("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    send("inf-inf",   32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
    send("nan in",    32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    send("underflow", 32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011);
    send("3-1",       32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
    send("1.5+1.5",   32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000);
    send("inf+1",     32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000);
    send("0+1",       32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);
    send("1+-1",      32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0000);
    send("1-2",       32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000);
    idle();
    drain();

    // Backpressure: out_ready low for 5 cycles with 4 ops offered
    bus.out_ready = 1'b0;
    fork
      begin
        send("bp0", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
        send("bp1", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);
        send("bp2", 32'h40800000, 32'h40800000, 1'b0, 32'h41000000, 4'b0000);
        send("bp3", 32'h41000000, 32'h41000000, 1'b0, 32'h41800000, 4'b0000);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        check_eq("bp in_ready low",   64'(bus.in_ready),  64'd0);
        check_eq("bp out_valid",      64'(bus.out_valid), 64'd1);
        check_eq("bp held data",      64'(bus.out_data),  64'h40000000);
        @(posedge clk); #1;
        check_eq("bp in_ready still", 64'(bus.in_ready),  64'd0);
        check_eq("bp held data 2",    64'(bus.out_data),  64'h40000000);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with operations in flight
    send("r0", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
    send("r1", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
    send("r2", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
    idle();
    rst_n = 1'b0;
    exp_q.delete();
    tag_q.delete();
    #1;
    check_eq("async reset out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_eq("post-reset in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    send("after reset", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000);
    idle();
    latency("latency after reset");
    drain();
    repeat (5) @(posedge clk);
    #1;
    check_eq("results lost", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
